// File: rtl/instr_fetch_issue.sv
// -----------------------------------------------------------------------------
// instr_fetch_issue
//   Instruction fetch/issue stage. It holds the PC and fetches one 32-bit MIPS
//   word at a time from instruction memory over a req/ack interface. Each word
//   is latched into an instruction register (IR) and its fields are handed to
//   the control decoder under a valid/ready handshake. The branch/execute
//   stage can redirect the PC at any time.
//
//   Optional feature (compile-time macro FETCH_JUMP_EN): J-format words
//   (opcode 6'b000010) are folded inside the fetch stage. The PC is loaded
//   with the jump target and no instruction is issued for the J word. When
//   the macro is undefined, J is issued like any other instruction.
//
// Parameters
//   RESET_PC     PC loaded on reset (bits [1:0] must be 0)
//
// Ports
//   clk          in   1   clock, all state updates on the rising edge
//   rst_n        in   1   asynchronous active-low reset
//   fetch_en     in   1   1 = fetching allowed; 0 = go idle once no request is open
//   imem_req     out  1   fetch request, held until imem_ack
//   imem_addr    out  32  byte address of the fetch (the current PC)
//   imem_ack     in   1   memory response valid this cycle
//   imem_rdata   in   32  instruction word, sampled when imem_req && imem_ack
//   issue_valid  out  1   decoded fields are valid for the decoder
//   issue_ready  in   1   decoder accepts the fields this cycle
//   opcode       out  6   IR[31:26]
//   funct        out  6   IR[5:0]
//   rs, rt, rd   out  5   IR[25:21], IR[20:16], IR[15:11]
//   imm          out  16  IR[15:0]
//   issue_pc     out  32  address of the issued instruction
//   redirect     in   1   one-cycle pulse: load PC from redirect_pc and flush
//   redirect_pc  in   32  redirect target (bits [1:0] forced to 0)
//   fsm_state    out  2   current FSM state (0 idle, 1 request, 2 issue)
// -----------------------------------------------------------------------------
// Handshakes:
//   - imem: a request is open while imem_req=1. imem_addr stays stable until a
//     cycle in which imem_ack=1, and that cycle completes the transfer. The
//     request is never withdrawn, except by reset or by a redirect. On a
//     redirect, an ack in the same cycle is discarded.
//   - issue: a transfer happens on a rising edge where issue_valid=1 and
//     issue_ready=1. While issue_valid=1 and issue_ready=0, all fields hold.
// -----------------------------------------------------------------------------
module instr_fetch_issue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        issue_valid,
    input  logic        issue_ready,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm,
    output logic [31:0] issue_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] pc_plus4;

    // Wraps modulo 2^32 naturally: 32'hFFFF_FFFC + 4 -> 0.
    assign pc_plus4 = pc + 32'd4;

`ifdef FETCH_JUMP_EN
    logic is_jump;
    assign is_jump = (imem_rdata[31:26] == 6'b000010);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            ir          <= 32'd0;
            issue_pc    <= 32'd0;
            imem_req    <= 1'b0;
            issue_valid <= 1'b0;
        end else if (redirect) begin
            // A redirect overrides everything. Any ack in this cycle is
            // dropped. An issue handshake in this cycle still counts as
            // consumed by the decoder.
            pc          <= redirect_pc & ~32'd3;
            issue_valid <= 1'b0;
            if (fetch_en) begin
                state    <= S_REQ;
                imem_req <= 1'b1;
            end else begin
                state    <= S_IDLE;
                imem_req <= 1'b0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (fetch_en) begin
                        state    <= S_REQ;
                        imem_req <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (imem_ack) begin
`ifdef FETCH_JUMP_EN
                        if (is_jump) begin
                            // Fold the jump. The request stays open and is
                            // sent to the target address on the next cycle.
                            pc <= {pc_plus4[31:28], imem_rdata[25:0], 2'b00};
                        end else begin
                            ir          <= imem_rdata;
                            issue_pc    <= pc;
                            pc          <= pc_plus4;
                            state       <= S_ISSUE;
                            imem_req    <= 1'b0;
                            issue_valid <= 1'b1;
                        end
`else
                        ir          <= imem_rdata;
                        issue_pc    <= pc;
                        pc          <= pc_plus4;
                        state       <= S_ISSUE;
                        imem_req    <= 1'b0;
                        issue_valid <= 1'b1;
`endif
                    end
                end
                S_ISSUE: begin
                    if (issue_ready) begin
                        issue_valid <= 1'b0;
                        if (fetch_en) begin
                            state    <= S_REQ;
                            imem_req <= 1'b1;
                        end else begin
                            state    <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    imem_req    <= 1'b0;
                    issue_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr = pc;
    assign opcode    = ir[31:26];
    assign rs        = ir[25:21];
    assign rt        = ir[20:16];
    assign rd        = ir[15:11];
    assign imm       = ir[15:0];
    assign funct     = ir[5:0];
    assign fsm_state = state;

endmodule

// File: tb/tb_instr_fetch_issue.sv
module tb_instr_fetch_issue;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        issue_valid;
  logic        issue_ready;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic [31:0] issue_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected issues: {pc, instruction word}.
  logic [63:0] exp_q[$];

  instr_fetch_issue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_en    (fetch_en),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .opcode      (opcode),
    .funct       (funct),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .imm         (imm),
    .issue_pc    (issue_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fsm_state   (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and move to the sampling point, 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for an open fetch request.
  task automatic wait_req(input string tag);
    for (int i = 0; i < 20 && imem_req !== 1'b1; i++) tick();
    chk({tag, "_req"}, {63'd0, imem_req}, 64'd1);
  endtask

  // Serve one fetch. Check the address, hold the request for lat cycles,
  // then ack with word. If push is set, record the expected issue.
  task automatic serve(input string tag, input logic [31:0] addr, input logic [31:0] word,
                       input int lat, input bit push);
    wait_req(tag);
    chk({tag, "_addr"}, {32'd0, imem_addr}, {32'd0, addr});
    for (int i = 0; i < lat; i++) begin
      tick();
      chk({tag, "_hold"}, {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, addr});
    end
    if (push) exp_q.push_back({addr, word});
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = $urandom();
  endtask

  // Pop the front expectation and compare it with the presented fields.
  task automatic compare_front(input string tag);
    logic [63:0] e;
    logic [31:0] w;
    if (exp_q.size() == 0) begin
      chk({tag, "_qempty"}, {63'd0, issue_valid}, 64'd0);
    end else begin
      e = exp_q.pop_front();
      w = e[31:0];
      chk({tag, "_pc"}, {32'd0, issue_pc}, {32'd0, e[63:32]});
      chk({tag, "_fields"}, {16'd0, opcode, rs, rt, rd, funct, imm},
          {16'd0, w[31:26], w[25:21], w[20:16], w[15:11], w[5:0], w[15:0]});
    end
  endtask

  // Accept one issue: wait (bounded) for valid, compare, complete the handshake.
  task automatic accept_issue(input string tag);
    issue_ready = 1'b1;
    for (int i = 0; i < 20 && issue_valid !== 1'b1; i++) tick();
    chk({tag, "_valid"}, {63'd0, issue_valid}, 64'd1);
    compare_front(tag);
    tick();
    issue_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] a;
    int          lat;
    int          stall;

    rst_n       = 1'b0;
    fetch_en    = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'd0;
    issue_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    repeat (3) tick();

    // reset state
    chk("rst_req", {63'd0, imem_req}, 64'd0);
    chk("rst_valid", {63'd0, issue_valid}, 64'd0);
    chk("rst_fields", {16'd0, opcode, rs, rt, rd, funct, imm}, 64'd0);
    chk("rst_issue_pc", {32'd0, issue_pc}, 64'd0);
    chk("rst_addr", {32'd0, imem_addr}, 64'd0);
    chk("rst_state", {62'd0, fsm_state}, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_req", {63'd0, imem_req}, 64'd0);

    // load word @0
    fetch_en = 1'b1;
    serve("lw", 32'h0, 32'h8C22_0004, 1, 1'b1);
    chk("lw_const", {32'd0, opcode, rs, rt, imm}, {32'd0, 6'h23, 5'd1, 5'd2, 16'h0004});
    accept_issue("lw");

    // R-type add @4, with the decoder stalling for 3 cycles
    serve("add", 32'h4, 32'h0022_1820, 0, 1'b1);
    chk("add_const", {38'd0, opcode, funct, rs, rt, rd},
        {38'd0, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3});
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall", {16'd0, issue_valid, imem_req, opcode, funct, rs, rt, rd, issue_pc[15:0]},
          {16'd0, 1'b1, 1'b0, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h0004});
    end
    accept_issue("add");

    // redirect while the request @8 is acked in the same cycle: the word is dropped
    wait_req("rd_req");
    chk("rd_pre_addr", {32'd0, imem_addr}, 64'h8);
    imem_ack    = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    redirect    = 1'b1;
    redirect_pc = 32'h43;
    tick();
    imem_ack = 1'b0;
    redirect = 1'b0;
    chk("rd_post", {30'd0, issue_valid, imem_req, imem_addr}, {30'd0, 1'b0, 1'b1, 32'h40});
    serve("rd_tgt", 32'h40, 32'h2008_0005, 2, 1'b1);

    // redirect in the issue state together with issue_ready: handshake completes
    issue_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    chk("rdi_valid", {63'd0, issue_valid}, 64'd1);
    compare_front("rdi");
    tick();
    issue_ready = 1'b0;
    redirect    = 1'b0;
    chk("rdi_post", {30'd0, issue_valid, imem_req, imem_addr}, {30'd0, 1'b0, 1'b1, 32'h100});

    // J word @0x100
`ifdef FETCH_JUMP_EN
    serve("j", 32'h100, 32'h0800_0010, 1, 1'b0);
    chk("j_fold", {30'd0, issue_valid, imem_req, imem_addr}, {30'd0, 1'b0, 1'b1, 32'h40});
`else
    serve("j", 32'h100, 32'h0800_0010, 1, 1'b1);
    chk("j_op", {58'd0, opcode}, 64'h02);
    accept_issue("j");
    chk("j_next", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h104});
`endif

    // redirect during an open request, no ack; low bits forced to 0; PC wraps
    wait_req("wrap_pre");
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    serve("wrap", 32'hFFFF_FFFC, 32'h0043_2025, 1, 1'b1);
    accept_issue("wrap");

    // fetch_en=0 during issue: go idle after the handshake
    serve("zero", 32'h0, 32'h3C01_1234, 0, 1'b1);
    fetch_en = 1'b0;
    accept_issue("zero");
    chk("idle1", {63'd0, imem_req}, 64'd0);
    tick();
    chk("idle2", {63'd0, imem_req}, 64'd0);

    // redirect while idle and fetch disabled: stay idle, PC updated
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    chk("idle_rd", {63'd0, imem_req}, 64'd0);
    fetch_en = 1'b1;
    tick();
    chk("idle_rd_go", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h200});

    // sequential run with random memory latency and random decoder stalls
    a = 32'h200;
    for (int k = 0; k < 8; k++) begin
      w = $urandom();
      if (w[31:26] == 6'b000010) w[31:26] = 6'h23;
      lat   = $urandom_range(0, 3);
      stall = $urandom_range(0, 2);
      serve("seq", a, w, lat, 1'b1);
      for (int i = 0; i < stall; i++) begin
        tick();
        chk("seq_stall", {62'd0, issue_valid, imem_req}, {62'd0, 1'b1, 1'b0});
      end
      accept_issue("seq");
      a = a + 32'd4;
    end

    // asynchronous reset in the middle of an open request
    wait_req("arst_pre");
    chk("arst_pre_addr", {32'd0, imem_addr}, {32'd0, a});
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_drop", {62'd0, imem_req, issue_valid}, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_after", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h0});

    chk("q_drained", {32'd0, exp_q.size()}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
